// File: rtl/ds_displace.sv
// Per-column random displacement stage for the diamond-square engine.
// Adds a step-scaled signed LFSR offset to the neighbour average and saturates.
module ds_displace #(
  parameter logic [15:0] SEED_BASE   = 16'hACE1,
  parameter int          ROUGH_SHIFT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  col_id,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic        rough_en,
  input  logic        in_valid,
  input  logic [7:0]  avg_in,
  input  logic [8:0]  step_size,
  output logic        out_valid,
  output logic [7:0]  out_val,
  output logic [15:0] lfsr_state
);

  localparam logic [15:0] TAPS = 16'hB400;

  // An all-zero Galois LFSR never leaves zero.
  function automatic logic [15:0] guard(
    input logic [15:0] v
  );
    return (v == 16'h0000) ? 16'h0001 : v;
  endfunction

  logic [15:0]       lfsr;
  logic [15:0]       lfsr_nxt;
  logic [8:0]        amp;
  logic [8:0]        mask;
  logic [8:0]        r;
  logic signed [10:0] off;

  logic              s1_valid;
  logic [7:0]        s1_avg;
  logic signed [10:0] s1_off;
  logic signed [10:0] sum;
  logic [7:0]        sat;

  always_comb begin
    lfsr_nxt = lfsr;
    unique case (1'b1)
      seed_load:
        lfsr_nxt = guard(seed_in ^ {7'b0, col_id});
      (in_valid && !seed_load):
        lfsr_nxt = {1'b0, lfsr[15:1]}
                 ^ (lfsr[0] ? TAPS : 16'h0000);
      default: ;
    endcase
  end

  // Mask gives r in [0, 2*amp-1]; subtracting amp centres it.
  always_comb begin
    amp  = step_size >> ROUGH_SHIFT;
    mask = (amp << 1) - 9'd1;
    r    = lfsr[8:0] & mask;
    off  = '0;
    if (rough_en && (amp != 9'd0))
      off = $signed({2'b00, r}) - $signed({2'b00, amp});
  end

  always_comb begin
    sum = $signed({3'b000, s1_avg}) + s1_off;
    if (sum < 0)
      sat = 8'h00;
    else if (sum > 11'sd255)
      sat = 8'hFF;
    else
      sat = sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= guard(SEED_BASE ^ {7'b0, col_id});
      s1_valid  <= 1'b0;
      s1_avg    <= '0;
      s1_off    <= '0;
      out_valid <= 1'b0;
      out_val   <= '0;
    end else begin
      lfsr      <= lfsr_nxt;
      s1_valid  <= in_valid;
      if (in_valid) begin
        s1_avg <= avg_in;
        s1_off <= off;
      end
      out_valid <= s1_valid;
      if (s1_valid)
        out_val <= sat;
    end
  end

  assign lfsr_state = lfsr;

endmodule
